// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
//   Stores one N-point frame of complex samples that arrive in natural order.
//   It then emits that frame in bit-reversed index order, which the
//   decimation-in-time butterflies expect. Sample values are not modified.
//
// Parameters
//   DATA_WIDTH  width of each RE/IM component
//   N           frame length (power of two, 4..1024)
//   LOG2N       index width, derived from N
//
// Ports
//   clock, reset_n           single clock; asynchronous active-low reset
//   in_valid/in_ready        input handshake
//   in_data                  complex sample, [0]=RE, [1]=IM
//   out_valid/out_ready      output handshake
//   out_data                 reordered complex sample (registered)
//   out_last                 marks the N-th output sample of a frame
//
// Build option
//   FFT_BITREV_PINGPONG_EN   two banks, so that filling one bank overlaps
//                            draining the other. When the macro is undefined,
//                            there is a single bank and in_ready is low for
//                            the whole drain.
module fft_bitrev_reorder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 16,
  parameter int unsigned LOG2N      = $clog2(N)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [0:1][DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [0:1][DATA_WIDTH-1:0] out_data,
  output logic                       out_last
);

  typedef logic [0:1][DATA_WIDTH-1:0] cplx_t;
  typedef logic [LOG2N-1:0]           idx_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  function automatic idx_t bitrev(input idx_t i);
    idx_t r;
    r = {<<{i}};
    return r;
  endfunction

  logic  run;
  logic  in_fire;
  logic  out_fire;
  logic  fill_done;
  logic  drain_done;
  logic  load_en;
  idx_t  wr_cnt;
  idx_t  rd_cnt;
  idx_t  rd_next;
  idx_t  load_idx;
  cplx_t rd_word;

  // in_ready stays low until the first edge after reset is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign fill_done  = in_fire && (wr_cnt == LAST_IDX);
  assign drain_done = out_fire && out_last;
  assign rd_next    = rd_cnt + 1'b1;

`ifdef FFT_BITREV_PINGPONG_EN

  typedef enum logic {F_FILL, F_WAIT}  fill_state_t;
  typedef enum logic {D_IDLE, D_DRAIN} drain_state_t;

  fill_state_t  fstate, fstate_next;
  drain_state_t dstate, dstate_next;
  logic         fill_bank;
  logic         drain_bank;
  logic         load_bank;
  logic         drain_free;
  logic         handover;
  cplx_t        mem [2][N];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fstate     <= F_FILL;
      dstate     <= D_IDLE;
      fill_bank  <= 1'b0;
      drain_bank <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
    end else begin
      fstate <= fstate_next;
      dstate <= dstate_next;
      if (in_fire) wr_cnt <= fill_done ? '0 : wr_cnt + 1'b1;
      if (handover) begin
        drain_bank <= fill_bank;
        fill_bank  <= ~fill_bank;
        rd_cnt     <= '0;
      end else if (out_fire) begin
        rd_cnt <= rd_next;
      end
    end
  end

  // A full bank moves to the drain side when the drain side is idle or is
  // finishing this cycle. That covers both a fill that just completed and
  // one that was parked in F_WAIT. So fill-complete and drain-complete in
  // the same cycle swap the banks with no bubble.
  always_comb begin
    fstate_next = fstate;
    dstate_next = dstate;
    drain_free  = (dstate == D_IDLE) || drain_done;
    handover    = drain_free && (fill_done || (fstate == F_WAIT));
    if (handover)       fstate_next = F_FILL;
    else if (fill_done) fstate_next = F_WAIT;
    if (handover)        dstate_next = D_DRAIN;
    else if (drain_done) dstate_next = D_IDLE;
  end

  always_comb begin
    in_ready  = run && (fstate == F_FILL);
    out_valid = (dstate == D_DRAIN);
    load_en   = handover || (out_fire && !out_last);
    load_idx  = handover ? '0 : rd_next;
    load_bank = handover ? fill_bank : drain_bank;
  end

  always_ff @(posedge clock) begin
    if (in_fire) mem[fill_bank][wr_cnt] <= in_data;
  end

  assign rd_word = mem[load_bank][bitrev(load_idx)];

`else

  typedef enum logic {FILL, DRAIN} state_t;

  state_t state, state_next;
  cplx_t  mem [N];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FILL;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      state <= state_next;
      if (in_fire) wr_cnt <= fill_done ? '0 : wr_cnt + 1'b1;
      if (fill_done)     rd_cnt <= '0;
      else if (out_fire) rd_cnt <= rd_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:  if (fill_done)  state_next = DRAIN;
      DRAIN: if (drain_done) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready  = run && (state == FILL);
    out_valid = (state == DRAIN);
    load_en   = fill_done || (out_fire && !out_last);
    load_idx  = fill_done ? '0 : rd_next;
  end

  always_ff @(posedge clock) begin
    if (in_fire) mem[wr_cnt] <= in_data;
  end

  assign rd_word = mem[bitrev(load_idx)];

`endif

  // The output register is preloaded with the next sample in bit-reversed
  // order. So out_data is valid in the same cycle that out_valid rises, and
  // it stays fixed while the output is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      out_last <= 1'b0;
    end else if (load_en) begin
      out_data <= rd_word;
      out_last <= (load_idx == LAST_IDX);
    end else if (drain_done) begin
      out_last <= 1'b0;
    end
  end

endmodule
